pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL provide: id_opcode  in  4  opcode of instruction in ID (IF_ID instr_out[15:12]).
REQ-004 SHALL provide: id_rs, id_rt  in  4 each  ID source register numbers; id_uses_rs, id_uses_rt  in  1 each  source-valid flags.
REQ-005 SHALL provide: ex_memread  in  1  EX instruction is a load; ex_rd  in  4  EX destination register.
REQ-006 SHALL provide: id_branch_taken  in  1  branch resolved taken in ID this cycle.
REQ-007 SHALL provide: mem_busy  in  1  multi-cycle instruction/data memory not ready.
REQ-008 SHALL provide: pc_wen  out  1  PC write enable; ifid_wen  out  1  drives IF_ID wen.
REQ-009 SHALL provide: ifid_flush  out  1  forces IF_ID instruction to NOP (0x0000) at next edge; idex_bubble  out  1  inserts NOP into ID_EX.
REQ-010 SHALL provide: pipe_freeze  out  1  holds ID_EX, EX_MEM, MEM_WB; halted  out  1; mem_timeout  out  1; stall_cycles  out  16.

Function
REQ-011 SHALL implement FSM states RUN, MEMWAIT, HALT (2-bit encoding); outputs are Mealy from state and current inputs.
REQ-012 SHALL define load-use hazard = ex_memread & (ex_rd != 0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-013 SHALL apply priority in RUN: mem_busy > halt (id_opcode==4'hF) > load-use hazard > id_branch_taken > normal.
REQ-014 RUN, normal: pc_wen=1, ifid_wen=1, all other control outputs 0.
REQ-015 RUN, mem_busy=1: pc_wen=0, ifid_wen=0, pipe_freeze=1, ifid_flush=0, idex_bubble=0; next state MEMWAIT.
REQ-016 MEMWAIT: same outputs as REQ-015 while mem_busy=1; when mem_busy=0, outputs evaluated as RUN in the same cycle and next state RUN (zero-cycle exit latency).
REQ-017 SHALL count consecutive MEMWAIT cycles in 8-bit counter; reaching 255 SHALL set mem_timeout sticky until reset; counter clears on MEMWAIT exit.
REQ-018 RUN, load-use: pc_wen=0, ifid_wen=0, idex_bubble=1, for exactly one cycle per hazard (hazard clears as load advances); state stays RUN.
REQ-019 RUN, branch taken (no higher-priority event): pc_wen=1, ifid_wen=1, ifid_flush=1 for one cycle.
REQ-020 RUN, halt opcode: pc_wen=0, ifid_wen=0, idex_bubble=0, halted=1 same cycle; next state HALT.
REQ-021 HALT: pc_wen=0, ifid_wen=0, ifid_flush=0, idex_bubble=0, pipe_freeze=0 (older instructions drain), halted=1; exit only via reset.
REQ-022 Halt opcode while mem_busy=1: MEMWAIT first; halt taken on first cycle mem_busy=0.
REQ-023 Load-use and branch same cycle: load-use wins; branch re-evaluated next cycle (ID instruction held).
REQ-024 stall_cycles SHALL increment each cycle pc_wen=0 in RUN or MEMWAIT, never in HALT, saturating at 0xFFFF (no wrap).
REQ-025 ex_rd==0 SHALL never produce a load-use stall.

Reset
REQ-026 rst=0 SHALL immediately (no clock) force state RUN, stall counter 0, MEMWAIT counter 0, mem_timeout 0, halted 0.
REQ-027 While rst=0: pc_wen=0, ifid_wen=0, ifid_flush=0, idex_bubble=0, pipe_freeze=0.
REQ-028 rst asserted mid-MEMWAIT or in HALT SHALL return to RUN on rst release; first edge after release behaves as RUN.

Verification
REQ-029 Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> one cycle pc_wen=0, ifid_wen=0, idex_bubble=1, stall_cycles +1; next cycle (ex_memread=0) normal.
REQ-030 ex_rd=0 variant of REQ-029 -> no stall, pc_wen=1; id_uses_rs=0 variant -> no stall.
REQ-031 Branch: id_branch_taken=1 alone -> ifid_flush=1, pc_wen=1 one cycle; with concurrent load-use -> idex_bubble=1, ifid_flush=0.
REQ-032 mem_busy high 4 cycles -> pipe_freeze=1, pc_wen=0 for 4 cycles, stall_cycles +4, no flush/bubble; high 255 cycles -> mem_timeout=1, stays 1 after mem_busy drops.
REQ-033 id_opcode=4'hF -> halted=1, pc_wen=0 permanently; rst pulse low -> halted=0, stall_cycles=0, RUN.
REQ-034 Preload stall_cycles near 0xFFFF via sustained mem_busy -> holds at 0xFFFF, no wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// The datapath (master) reports the ID/EX situation; the controller (slave) returns the stall/flush controls.
interface pipe_hazard_ctrl_if;
  logic [3:0]  id_opcode;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [3:0]  ex_rd;
  logic        id_branch_taken;
  logic        mem_busy;
  logic        pc_wen;
  logic        ifid_wen;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        pipe_freeze;
  logic        halted;
  logic        mem_timeout;
  logic [15:0] stall_cycles;

  modport master (
    output id_opcode, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_memread, ex_rd, id_branch_taken, mem_busy,
    input  pc_wen, ifid_wen, ifid_flush, idex_bubble, pipe_freeze,
           halted, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_memread, ex_rd, id_branch_taken, mem_busy,
    output pc_wen, ifid_wen, ifid_flush, idex_bubble, pipe_freeze,
           halted, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, halt, load-use bubble and taken-branch flush.
// Control outputs are Mealy so a memory wait ends with no extra cycle of latency.
module pipe_hazard_ctrl (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_q, stall_d;

  logic loadUse;
  logic pcWen, ifidWen, ifidFlush, idexBubble, pipeFreeze, haltedOut;

  assign loadUse = hz.ex_memread && (hz.ex_rd != 4'd0) &&
                   ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                    (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));

  // Priority chain evaluated in RUN, and in MEMWAIT once memory is ready, so exit costs no cycle.
  always_comb begin
    pcWen      = 1'b0;
    ifidWen    = 1'b0;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    pipeFreeze = 1'b0;
    haltedOut  = 1'b0;
    state_d    = state_q;
    waitCnt_d  = 8'd0;
    timeout_d  = timeout_q;
    stall_d    = stall_q;
    if (rst) begin
      case (state_q)
        HALT: begin
          haltedOut = 1'b1;
        end
        default: begin
          if (hz.mem_busy) begin
            pipeFreeze = 1'b1;
            state_d    = MEMWAIT;
            waitCnt_d  = (waitCnt_q == 8'hFF) ? 8'hFF : waitCnt_q + 8'd1;
            if (waitCnt_d == 8'hFF) timeout_d = 1'b1;
          end else if (hz.id_opcode == 4'hF) begin
            haltedOut = 1'b1;
            state_d   = HALT;
          end else if (loadUse) begin
            idexBubble = 1'b1;
            state_d    = RUN;
          end else if (hz.id_branch_taken) begin
            pcWen     = 1'b1;
            ifidWen   = 1'b1;
            ifidFlush = 1'b1;
            state_d   = RUN;
          end else begin
            pcWen   = 1'b1;
            ifidWen = 1'b1;
            state_d = RUN;
          end
          if (!pcWen && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      waitCnt_q <= 8'd0;
      timeout_q <= 1'b0;
      stall_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  assign hz.pc_wen       = pcWen;
  assign hz.ifid_wen     = ifidWen;
  assign hz.ifid_flush   = ifidFlush;
  assign hz.idex_bubble  = idexBubble;
  assign hz.pipe_freeze  = pipeFreeze;
  assign hz.halted       = haltedOut;
  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl against a cycle-level behavioural model.
// The model only remembers whether the core is halted, the current busy run length and the counters.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  int checkCount = 0;
  int missCount  = 0;

  bit mHalted  = 1'b0;
  int mStall   = 0;
  int mRun     = 0;
  bit mTimeout = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One cycle: drive inputs mid-period, compare everything, then advance the model past the next edge.
  task automatic applyStimulus(input bit r, input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                               input bit urs, input bit urt, input bit emr, input logic [3:0] erd,
                               input bit br, input bit busy);
    bit ePc, eIfid, eFlush, eBubble, eFreeze, eHalted, lu;
    @(negedge clk);
    rst                = r;
    hz.id_opcode       = op;
    hz.id_rs           = rs;
    hz.id_rt           = rt;
    hz.id_uses_rs      = urs;
    hz.id_uses_rt      = urt;
    hz.ex_memread      = emr;
    hz.ex_rd           = erd;
    hz.id_branch_taken = br;
    hz.mem_busy        = busy;
    #1;
    if (!r) begin
      mHalted  = 1'b0;
      mStall   = 0;
      mRun     = 0;
      mTimeout = 1'b0;
    end
    lu = emr && (erd != 4'd0) && ((urs && rs == erd) || (urt && rt == erd));
    ePc = 0; eIfid = 0; eFlush = 0; eBubble = 0; eFreeze = 0; eHalted = 0;
    if (!r) begin
    end else if (mHalted) begin
      eHalted = 1;
    end else if (busy) begin
      eFreeze = 1;
    end else if (op == 4'hF) begin
      eHalted = 1;
    end else if (lu) begin
      eBubble = 1;
    end else begin
      ePc = 1; eIfid = 1; eFlush = br;
    end
    checkOutput("pc_wen",       32'(hz.pc_wen),       32'(ePc));
    checkOutput("ifid_wen",     32'(hz.ifid_wen),     32'(eIfid));
    checkOutput("ifid_flush",   32'(hz.ifid_flush),   32'(eFlush));
    checkOutput("idex_bubble",  32'(hz.idex_bubble),  32'(eBubble));
    checkOutput("pipe_freeze",  32'(hz.pipe_freeze),  32'(eFreeze));
    checkOutput("halted",       32'(hz.halted),       32'(eHalted));
    checkOutput("mem_timeout",  32'(hz.mem_timeout),  32'(mTimeout));
    checkOutput("stall_cycles", 32'(hz.stall_cycles), 32'(mStall));
    if (r) begin
      if (!mHalted && !ePc && mStall < 65535) mStall++;
      if (busy && !mHalted) begin
        if (mRun < 255) mRun++;
        if (mRun == 255) mTimeout = 1'b1;
      end else begin
        mRun = 0;
      end
      if (eHalted) mHalted = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 4'h1, 4'h1, 4'h2, 1, 1, 0, 4'h0, 0, 0);
  endtask

  task automatic randomCycle();
    bit r;
    logic [3:0] op;
    r  = !(($urandom_range(0, 199) == 0) || (mHalted && $urandom_range(0, 9) == 0));
    op = ($urandom_range(0, 79) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    applyStimulus(r, op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 6) == 0));
  endtask

  initial begin
    hz.id_opcode = 4'h0; hz.id_rs = 4'h0; hz.id_rt = 4'h0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
    hz.ex_memread = 0; hz.ex_rd = 4'h0; hz.id_branch_taken = 0; hz.mem_busy = 0;

    applyStimulus(0, 4'h1, 4'h3, 4'h0, 1, 0, 1, 4'h3, 1, 1);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    idle(2);

    // Load-use, then the load advances and the pipe runs normally.
    applyStimulus(1, 4'h1, 4'h3, 4'h0, 1, 0, 1, 4'h3, 0, 0);
    applyStimulus(1, 4'h1, 4'h3, 4'h0, 1, 0, 0, 4'h3, 0, 0);
    applyStimulus(1, 4'h1, 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 0);
    applyStimulus(1, 4'h1, 4'h3, 4'h0, 0, 0, 1, 4'h3, 0, 0);
    applyStimulus(1, 4'h1, 4'h0, 4'h5, 0, 1, 1, 4'h5, 0, 0);

    // Branch alone, then branch against a concurrent load-use.
    applyStimulus(1, 4'h2, 4'h1, 4'h2, 1, 1, 0, 4'h0, 1, 0);
    applyStimulus(1, 4'h2, 4'h3, 4'h0, 1, 0, 1, 4'h3, 1, 0);
    applyStimulus(1, 4'h2, 4'h3, 4'h0, 1, 0, 0, 4'h3, 1, 0);

    // Short memory wait, then a long one that trips the timeout.
    for (int i = 0; i < 4; i++) applyStimulus(1, 4'h1, 4'h3, 4'h0, 1, 0, 1, 4'h3, 1, 1);
    idle(2);
    for (int i = 0; i < 255; i++) applyStimulus(1, 4'h1, 4'h1, 4'h1, 0, 0, 0, 4'h0, 0, 1);
    idle(3);

    // Halt requested while memory is busy, taken once memory is ready; reset brings the core back.
    applyStimulus(1, 4'hF, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    applyStimulus(1, 4'hF, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h1, 4'h3, 4'h0, 1, 0, 1, 4'h3, 1, 1);
    applyStimulus(1, 4'h1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1, 0);
    applyStimulus(0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    idle(2);

    for (int i = 0; i < 4000; i++) randomCycle();

    // Long busy stretch pushes the stall counter into saturation.
    applyStimulus(0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    for (int i = 0; i < 65540; i++) applyStimulus(1, 4'h1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'h1, 4'h6, 4'h0, 1, 0, 1, 4'h6, 0, 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
    $finish;
  end

endmodule
